cjb_mmio_port_v: RTL
====================

# cjb_mmio_port_v

Memory-mapped I/O responder for the cjbRISC_HMMIOP processor: the target end of the CPU's MAR/RW/IPDR/OPDR data-memory accesses. It decodes three high addresses and serves them from the board pins:
- synchronizes and debounces push-button PB1 and the 4 switches for reads;
- latches a sticky button-press event with an optional interrupt;
- holds the LED output register written by the CPU.

## Interface
Parameters:
- DB_CYCLES, 4: consecutive synchronized cycles PB1 must differ from its debounced value before that value changes; legal range 1..255.
- ADDR_DIN, 10'h3FC: data-input register address (read-only).
- ADDR_STAT, 10'h3FD: status/control register address.
- ADDR_LED, 10'h3FE: LED output register address.

Ports:
- Clock  in  1  system clock; all state changes on its rising edge.
- Reset  in  1  asynchronous, active-low reset.
- Addr  in  10  access address (driven from MARout).
- Req  in  1  one-cycle access strobe; Addr, RW and WrData are valid while Req=1.
- RW  in  1  1=read, 0=write.
- WrData  in  8  write data (from OPDR).
- RdData  out  8  registered read data (to IPDR).
- Ack  out  1  registered one-cycle access acknowledge.
- PB1  in  1  raw asynchronous push-button.
- SW  in  4  raw asynchronous switches.
- LEDs  out  8  LED register.
- Irq  out  1  press-event interrupt, level; Irq = EVT & IE.

## Operation
- Synchronizers: PB1 and SW each pass through a 2-flop synchronizer; pb_s and sw_s are the second-stage outputs.
- Debounce (pb_db):
  - 8-bit counter cnt. When pb_s == pb_db, cnt clears to 0.
  - When pb_s != pb_db and cnt == DB_CYCLES-1, pb_db toggles and cnt clears.
  - Otherwise cnt increments.
  - A glitch shorter than DB_CYCLES cycles never reaches pb_db.
- EVT: sticky bit, set on the edge where pb_db goes 0->1. Release (1->0) does not set it.
- Register map:
  - ADDR_DIN read = {3'b000, pb_db, sw_s[3:0]}. Writes are acked and ignored.
  - ADDR_STAT read = {IE, 5'b0, pb_db, EVT}.
  - ADDR_STAT write: bit7 loads IE; bit0=1 clears EVT (write-1-to-clear); all other bits ignored.
  - ADDR_LED: read returns LEDs; write loads LEDs from WrData.
- Access, decided by Req at edge n:
  - Mapped address: Ack=1 at edge n+1. For a read, RdData is valid at edge n+1 and holds the value sampled at edge n. The write takes effect at edge n.
  - Unmapped address: Ack stays 0, RdData is 0, no state changes.
  - Without Req: Ack=0, RdData=0.
- Simultaneous events:
  - An EVT set and a W1C clear on the same edge: the set wins, EVT=1.
  - A STAT read on the same edge that EVT sets returns the old value, EVT=0.
- Back-to-back Req on consecutive cycles is legal; each access gets its own Ack.

## Timing
- Reset (asynchronous assert, synchronous-safe release) forces to 0: LEDs, RdData, Ack, Irq, IE, EVT, pb_db, cnt and all synchronizer flops.
- PB1 rise first sampled at edge 0: pb_s=1 after edge 1, pb_db=1 and EVT=1 after edge 1+DB_CYCLES (edge 5 at the default). Irq rises in the same cycle if IE=1.
- SW to DIN read latency: 2 edges of synchronization, then the 1-cycle access.
- Irq is combinational from registers only; it is glitch-free.
- Reset asserted mid-access: the pending Ack is cancelled, and no write lands unless its edge preceded reset.

## Test plan
- Reset: hold Reset=0 with PB1=1 and SW=4'hF -> LEDs=8'h00, Ack=0, RdData=0, Irq=0. Release -> DIN read returns 8'h1F once pb_db has settled.
- LED write/read: Req, RW=0, Addr=3FE, WrData=A5 -> LEDs=A5 after the edge and Ack pulse next cycle. Then read 3FE -> RdData=A5 with Ack.
- Debounce: PB1 high for 3 synced cycles, then low -> EVT stays 0. PB1 high held -> pb_db=1 and EVT=1 exactly 5 edges after first sample. STAT read = 8'h03.
- Interrupt: write STAT=8'h80 -> IE=1, Irq=1 with EVT set. Write STAT=8'h81 -> EVT=0, Irq=0, IE stays 1. Force a press on the same edge as a W1C -> EVT=1.
- Unmapped: Req read at Addr=3FB and Addr=000 -> Ack=0, RdData=0, LEDs unchanged.
- Back-to-back: three consecutive Req (write 3FE=3C, read 3FE, read 3FD) -> three consecutive Ack pulses, RdData=3C and then the status value.

Source files
------------

// File: rtl/cjb_mmio_port_v_if.sv
// ----------------------------------------------------------------------------
// cjb_mmio_port_v_if
//   CPU-side data-memory access bus of the cjbRISC_HMMIOP processor as seen by
//   the MMIO responder.
//
//   Addr    [9:0]  access address (from MARout)
//   Req            one-cycle access strobe; Addr/RW/WrData valid while high
//   RW             1 = read, 0 = write
//   WrData  [7:0]  write data (from OPDR)
//   RdData  [7:0]  registered read data (to IPDR)
//   Ack            registered one-cycle acknowledge
//
//   master : the CPU (drives the request, receives RdData/Ack)
//   slave  : the responder
// ----------------------------------------------------------------------------
interface cjb_mmio_port_v_if;
    logic [9:0] Addr;
    logic       Req;
    logic       RW;
    logic [7:0] WrData;
    logic [7:0] RdData;
    logic       Ack;

    modport master (
        output Addr,
        output Req,
        output RW,
        output WrData,
        input  RdData,
        input  Ack
    );

    modport slave (
        input  Addr,
        input  Req,
        input  RW,
        input  WrData,
        output RdData,
        output Ack
    );
endinterface

// File: rtl/cjb_mmio_port_v.sv
// ----------------------------------------------------------------------------
// cjb_mmio_port_v
//   Memory-mapped I/O responder for the cjbRISC_HMMIOP processor. Serves three
//   high addresses from the board pins:
//     ADDR_DIN  (RO) : {3'b000, pb_db, sw_s[3:0]}
//     ADDR_STAT (RW) : read {IE, 5'b0, pb_db, EVT}; write bit7 -> IE,
//                      bit0 = 1 clears EVT
//     ADDR_LED  (RW) : LED output register
//   PB1 and SW are double-flop synchronised; PB1 is additionally debounced.
//   A rising edge of the debounced button sets the sticky EVT bit, which
//   raises Irq when IE is set.
//
//   Ports:
//     Clock        system clock, rising edge
//     Reset        asynchronous active-low reset
//     bus          access bus (slave modport): Addr, Req, RW, WrData,
//                  RdData, Ack
//     PB1          raw asynchronous push-button
//     SW[3:0]      raw asynchronous switches
//     LEDs[7:0]    LED register
//     Irq          press-event interrupt, level, EVT & IE
// ----------------------------------------------------------------------------
module cjb_mmio_port_v #(
    parameter int         DB_CYCLES = 4,
    parameter logic [9:0] ADDR_DIN  = 10'h3FC,
    parameter logic [9:0] ADDR_STAT = 10'h3FD,
    parameter logic [9:0] ADDR_LED  = 10'h3FE
) (
    input  logic                  Clock,
    input  logic                  Reset,
    cjb_mmio_port_v_if.slave      bus,
    input  logic                  PB1,
    input  logic [3:0]            SW,
    output logic [7:0]            LEDs,
    output logic                  Irq
);

    localparam logic [7:0] DB_LAST = 8'(DB_CYCLES - 1);

    // synchroniser stages
    logic       pb_meta_p0;
    logic       pb_s;
    logic [3:0] sw_meta_p0;
    logic [3:0] sw_s;

    // debounce / event state
    logic [7:0] cnt;
    logic       pb_db;
    logic       evt;
    logic       ie;

    // access decode
    logic       hit_din;
    logic       hit_stat;
    logic       hit_led;
    logic       acc_ok;
    logic       stat_wr;
    logic       led_wr;
    logic       db_toggle;
    logic       evt_set;
    logic       evt_clr;
    logic [7:0] rd_next;

    function automatic logic [7:0] read_mux(
        input logic       sel_din,
        input logic       sel_stat,
        input logic       db,
        input logic [3:0] sw,
        input logic       ie_v,
        input logic       evt_v,
        input logic [7:0] led
    );
        if (sel_din)
            return {3'b000, db, sw};
        else if (sel_stat)
            return {ie_v, 5'b00000, db, evt_v};
        else
            return led;
    endfunction

    always_comb begin
        hit_din   = (bus.Addr == ADDR_DIN);
        hit_stat  = (bus.Addr == ADDR_STAT);
        hit_led   = (bus.Addr == ADDR_LED);
        acc_ok    = bus.Req && (hit_din || hit_stat || hit_led);
        stat_wr   = acc_ok && !bus.RW && hit_stat;
        led_wr    = acc_ok && !bus.RW && hit_led;
        // The debounced level flips on the DB_CYCLES-th consecutive
        // disagreeing sample.
        db_toggle = (pb_s != pb_db) && (cnt == DB_LAST);
        evt_set   = db_toggle && !pb_db;
        evt_clr   = stat_wr && bus.WrData[0];
        // Reads sample the pre-edge register values, so a STAT read on the
        // same edge that EVT sets still reports the old EVT.
        rd_next   = 8'h00;
        if (acc_ok && bus.RW)
            rd_next = read_mux(hit_din, hit_stat, pb_db, sw_s, ie, evt, LEDs);
    end

    // Irq is a pure AND of two flops, so it cannot glitch.
    assign Irq = evt & ie;

    // ---- stage p0 -> s : two-flop synchronisers ----
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            pb_meta_p0 <= 1'b0;
            pb_s       <= 1'b0;
            sw_meta_p0 <= 4'h0;
            sw_s       <= 4'h0;
        end else begin
            pb_meta_p0 <= PB1;
            pb_s       <= pb_meta_p0;
            sw_meta_p0 <= SW;
            sw_s       <= sw_meta_p0;
        end
    end

    // ---- debounce and sticky press event ----
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            cnt   <= 8'h00;
            pb_db <= 1'b0;
            evt   <= 1'b0;
            ie    <= 1'b0;
        end else begin
            if (pb_s == pb_db) begin
                cnt <= 8'h00;
            end else if (db_toggle) begin
                pb_db <= ~pb_db;
                cnt   <= 8'h00;
            end else begin
                cnt <= cnt + 8'h01;
            end
            // A set on the same edge as a write-1-to-clear wins.
            evt <= evt_set | (evt & ~evt_clr);
            if (stat_wr)
                ie <= bus.WrData[7];
        end
    end

    // ---- access response and LED register ----
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            LEDs       <= 8'h00;
            bus.Ack    <= 1'b0;
            bus.RdData <= 8'h00;
        end else begin
            if (led_wr)
                LEDs <= bus.WrData;
            bus.Ack    <= acc_ok;
            bus.RdData <= rd_next;
        end
    end

endmodule
